// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the systolic-array input feeder.
package sys_arr_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/sys_skew_lane.sv
// Fixed-depth delay line for one lane of the skew stage; the last stage is the output register.
module sys_skew_lane #(
   parameter int depth  = 1,
   parameter int LANE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LANE_W-1:0] lane_in,
   output logic [LANE_W-1:0] lane_out
);

   logic [LANE_W-1:0] stage_q [depth];
   logic [LANE_W-1:0] stage_d [depth];

   always_comb begin
      stage_d[0] = lane_in;
      for (int i = 1; i < depth; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < depth; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < depth; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign lane_out = stage_q[depth-1];

endmodule

// File: rtl/sys_arr_feeder.sv
// Skews unskewed row vectors diagonally into the systolic array and brackets
// each matrix with drain cycles before returning to idle.
module sys_arr_feeder
   import sys_arr_pkg::*;
#(
   parameter int width_height = 4,
   parameter int data_width   = 8 * width_height
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_data,
   input  logic                  in_last,
   output logic [data_width-1:0] datain,
   output logic                  active,
   output logic                  done,
   output state_t                dbg_state
);

   localparam int N     = width_height;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic             accept;
   logic [data_width-1:0] lane_src;

   // Handshake: a row transfers on a rising edge when in_valid & in_ready;
   // in_ready depends only on state, never on in_valid.
   assign in_ready = (state_q != DRAIN);
   assign accept   = in_valid & in_ready;
   assign lane_src = accept ? in_data : '0;

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      done_d      = 1'b0;
      active_d    = accept | (state_q == FEED) | (state_q == DRAIN);
      unique case (state_q)
         IDLE, FEED: begin
            if (accept) begin
               if (in_last) begin
                  if (N == 1) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d     = DRAIN;
                     drain_cnt_d = CNT_LOAD;
                  end
               end else begin
                  state_d = FEED;
               end
            end
         end
         DRAIN: begin
            // Leaving on count 1 makes the last drain cycle coincide with the final lane's data.
            if (drain_cnt_q <= CNT_ONE) begin
               state_d     = IDLE;
               drain_cnt_d = '0;
               done_d      = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d     = IDLE;
            drain_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         active_q    <= active_d;
         done_q      <= done_d;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      sys_skew_lane #(
         .depth  (k + 1),
         .LANE_W (LANE_W)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .lane_in  (lane_src[k*LANE_W +: LANE_W]),
         .lane_out (datain[k*LANE_W +: LANE_W])
      );
   end

   assign active    = active_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Directed and randomized checks of the feeder against a timing-based reference model.
module tb_sys_arr_feeder;
   import sys_arr_pkg::*;

   localparam int N = 4;
   localparam int W = 8 * N;

   typedef struct packed {
      logic [W-1:0] data;
      logic         act;
      logic         dn;
      logic         rdy;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
   logic [W-1:0] datain;
   logic         active;
   logic         done;
   state_t       dbg_state;

   exp_t         exp_q[$];
   logic [W-1:0] hist[$];
   int           e;
   int           last_e;
   int           act_end;
   bit           in_feed;
   bit           m_ready;
   int           n_pass = 0;
   int           n_total = 0;

   sys_arr_feeder #(.width_height(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .datain    (datain),
      .active    (active),
      .done      (done),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      hist.delete();
      exp_q.delete();
      e       = 0;
      last_e  = -100;
      act_end = -100;
      in_feed = 1'b0;
      m_ready = 1'b1;
   endtask

   // One clock: drive at negedge, predict, then compare 1 time unit after the posedge.
   task automatic step(input bit v, input bit l, input logic [W-1:0] d,
                       output bit acc, output logic [W-1:0] obs);
      exp_t         x;
      logic [W-1:0] hv;
      @(negedge clk);
      in_valid = v;
      in_last  = l;
      in_data  = d;
      acc = v && m_ready;
      hist.push_back(acc ? d : '0);
      if (acc) begin
         if (l) begin
            in_feed = 1'b0;
            last_e  = e;
            act_end = e + N - 1;
         end else begin
            in_feed = 1'b1;
         end
      end
      x.act  = in_feed || (e <= act_end);
      x.dn   = (e == act_end);
      x.rdy  = !(e >= last_e && e <= last_e + N - 2);
      x.data = '0;
      for (int k = 0; k < N; k++) begin
         if (e - k >= 0) begin
            hv = hist[e-k];
            x.data[8*k +: 8] = hv[8*k +: 8];
         end
      end
      exp_q.push_back(x);
      m_ready = x.rdy;
      e++;
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      obs = datain;
      check("datain", datain, x.data);
      check("active", W'(active), W'(x.act));
      check("done", W'(done), W'(x.dn));
      check("in_ready", W'(in_ready), W'(x.rdy));
   endtask

   task automatic idle(input int n);
      bit           acc;
      logic [W-1:0] obs;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, acc, obs);
   endtask

   // Holds a row with in_valid high until the model says it was taken.
   task automatic send_row(input logic [W-1:0] d, input bit l, output int acc_e);
      bit           acc;
      logic [W-1:0] obs;
      int           tries;
      tries = 0;
      acc   = 1'b0;
      acc_e = -1;
      while (!acc && tries < 20) begin
         step(1'b1, l, d, acc, obs);
         tries++;
      end
      check("accept_timeout", W'(acc), W'(1));
      if (acc) acc_e = e - 1;
   endtask

   task automatic async_reset_check(input string tag);
      #2;
      reset = 1'b1;
      #1;
      check({tag, "_datain"}, datain, '0);
      check({tag, "_active"}, W'(active), '0);
      check({tag, "_done"}, W'(done), '0);
      check({tag, "_in_ready"}, W'(in_ready), W'(1));
      check({tag, "_state"}, W'(dbg_state), W'(IDLE));
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [W-1:0] three_tbl [7];
      logic [W-1:0] single_tbl [5];
      logic [W-1:0] obs;
      bit           acc;
      int           acc_e;
      int           rows;

      three_tbl  = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A00,
                     32'h080B0000, 32'h0C000000, 32'h00000000};
      single_tbl = '{32'h0000000A, 32'h00000B00, 32'h000C0000, 32'h0D000000, 32'h00000000};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      model_reset();
      #1;
      check("rst_datain", datain, '0);
      check("rst_active", W'(active), '0);
      check("rst_done", W'(done), '0);
      check("rst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      reset = 1'b0;

      // Three-row matrix, basic skew
      step(1'b1, 1'b0, 32'h04030201, acc, obs);
      check("three_e0", obs, three_tbl[0]);
      step(1'b1, 1'b0, 32'h08070605, acc, obs);
      check("three_e1", obs, three_tbl[1]);
      step(1'b1, 1'b1, 32'h0C0B0A09, acc, obs);
      check("three_e2", obs, three_tbl[2]);
      for (int i = 3; i < 7; i++) begin
         step(1'b1, 1'b0, 32'hDEADBEEF, acc, obs);
         if (i < 6) check("three_table", obs, three_tbl[i]);
      end
      idle(2);

      // Gap: in_last without in_valid is ignored and a zero slot is inserted
      step(1'b1, 1'b0, 32'h04030201, acc, obs);
      step(1'b0, 1'b1, 32'hFFFFFFFF, acc, obs);
      step(1'b1, 1'b0, 32'h08070605, acc, obs);
      step(1'b1, 1'b1, 32'h0C0B0A09, acc, obs);
      idle(2);
      step(1'b0, 1'b0, '0, acc, obs);
      check("gap_final", obs, 32'h0C000000);
      check("gap_done", W'(done), W'(1));
      idle(2);

      // Single row from idle
      step(1'b1, 1'b1, 32'h0D0C0B0A, acc, obs);
      check("single_e0", obs, single_tbl[0]);
      for (int i = 1; i < 5; i++) begin
         step(1'b0, 1'b0, '0, acc, obs);
         check("single_table", obs, single_tbl[i]);
      end
      idle(1);

      // Reset in the middle of DRAIN, then a fresh matrix
      step(1'b1, 1'b0, 32'h04030201, acc, obs);
      step(1'b1, 1'b0, 32'h08070605, acc, obs);
      step(1'b1, 1'b1, 32'h0C0B0A09, acc, obs);
      step(1'b0, 1'b0, '0, acc, obs);
      async_reset_check("rst_drain");
      step(1'b1, 1'b0, 32'h04030201, acc, obs);
      check("post_rst_e0", obs, three_tbl[0]);
      step(1'b1, 1'b0, 32'h08070605, acc, obs);
      step(1'b1, 1'b1, 32'h0C0B0A09, acc, obs);
      check("post_rst_e2", obs, three_tbl[2]);
      idle(N + 1);

      // Back-to-back matrices with in_valid held high
      async_reset_check("rst_b2b");
      send_row(32'h11111111, 1'b0, acc_e);
      send_row(32'h22222222, 1'b0, acc_e);
      send_row(32'h33333333, 1'b1, acc_e);
      send_row(32'h44444444, 1'b0, acc_e);
      check("b2b_accept_edge", W'(acc_e), W'(2 + N));
      send_row(32'h55555555, 1'b1, acc_e);
      idle(N + 1);

      // Randomized matrices with random gaps
      for (int m = 0; m < 6; m++) begin
         rows = $urandom_range(1, 5);
         for (int r = 0; r < rows; r++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'(($urandom_range(0, 1))), $urandom, acc, obs);
            send_row($urandom, (r == rows - 1), acc_e);
         end
         idle($urandom_range(0, 3));
      end
      idle(N + 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
